// File: rtl/int_div_unit.sv
// int_div_unit: fixed-latency radix-2 restoring divider (DIV/DIVU/REM/REMU) with mispredict squash.
module int_div_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 7,
  parameter int SQN_W = 7,
  parameter int ITERS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IN_valid,
  input  logic [1:0]       IN_opcode,
  input  logic [XLEN-1:0]  IN_srcA,
  input  logic [XLEN-1:0]  IN_srcB,
  input  logic [TAG_W-1:0] IN_tagDst,
  input  logic [SQN_W-1:0] IN_sqN,
  input  logic             IN_branchTaken,
  input  logic [SQN_W-1:0] IN_branchSqN,
  output logic             OUT_busy,
  output logic             OUT_valid,
  output logic [XLEN-1:0]  OUT_result,
  output logic [TAG_W-1:0] OUT_tagDst,
  output logic [SQN_W-1:0] OUT_sqN
);
  localparam int CW = $clog2(ITERS);
  localparam logic [CW-1:0] CNT_INIT = CW'(ITERS - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] op_q, op_d;
  logic neg_a_q, neg_a_d, neg_b_q, neg_b_d, valid_q, valid_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [SQN_W-1:0] sqn_q, sqn_d;
  logic [XLEN:0] trial;
  logic [XLEN-1:0] rem_n, quo_n, q_fix, r_fix;
  logic sgn_in, na_in, nb_in;
  function automatic logic younger(input logic [SQN_W-1:0] s);
    logic [SQN_W-1:0] d;
    d = s - IN_branchSqN;
    return !d[SQN_W-1] && (d != '0);
  endfunction
  // One restoring step; the final step is folded into DONE so latency stays ITERS+1.
  assign trial = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};
  assign rem_n = trial[XLEN] ? {rem_q[XLEN-2:0], quo_q[XLEN-1]} : trial[XLEN-1:0];
  assign quo_n = {quo_q[XLEN-2:0], ~trial[XLEN]};
  // Divide-by-zero keeps the all-ones quotient whatever the dividend sign.
  assign q_fix = ((neg_a_q ^ neg_b_q) && (dvs_q != '0)) ? -quo_n : quo_n;
  assign r_fix = neg_a_q ? -rem_n : rem_n;
  assign sgn_in = !IN_opcode[0];
  assign na_in = sgn_in && IN_srcA[XLEN-1];
  assign nb_in = sgn_in && IN_srcB[XLEN-1];
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    res_d = res_q;
    cnt_d = cnt_q;
    op_d = op_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    tag_d = tag_q;
    sqn_d = sqn_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: if (IN_valid && !(IN_branchTaken && younger(IN_sqN))) begin
        state_d = RUN;
        rem_d = '0;
        quo_d = na_in ? -IN_srcA : IN_srcA;
        dvs_d = nb_in ? -IN_srcB : IN_srcB;
        cnt_d = CNT_INIT;
        op_d = IN_opcode;
        neg_a_d = na_in;
        neg_b_d = nb_in;
        tag_d = IN_tagDst;
        sqn_d = IN_sqN;
      end
      RUN: begin
        rem_d = rem_n;
        quo_d = quo_n;
        cnt_d = cnt_q - CNT_ONE;
        state_d = (cnt_q == CNT_ONE) ? DONE : RUN;
      end
      default: begin
        res_d = op_q[1] ? r_fix : q_fix;
        valid_d = 1'b1;
        state_d = IDLE;
      end
    endcase
    if (state_q != IDLE && IN_branchTaken && younger(sqn_q)) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      res_q <= '0;
      cnt_q <= '0;
      op_q <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      tag_q <= '0;
      sqn_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      res_q <= res_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      tag_q <= tag_d;
      sqn_q <= sqn_d;
      valid_q <= valid_d;
    end
  end
  assign OUT_busy = state_q != IDLE;
  assign OUT_valid = valid_q;
  assign OUT_result = res_q;
  assign OUT_tagDst = tag_q;
  assign OUT_sqN = sqn_q;
  a_no_issue_busy: assert property (@(posedge clk) disable iff (rst) !(IN_valid && OUT_busy))
    else $warning("divide issued while unit busy; ignored");
endmodule

// File: tb/tb_int_div_unit.sv
// tb_int_div_unit: directed and random checks of int_div_unit against an arithmetic reference.
module tb_int_div_unit;
  logic clk = 1'b0, rst = 1'b1;
  logic IN_valid = 1'b0, IN_branchTaken = 1'b0;
  logic [1:0] IN_opcode = '0;
  logic [31:0] IN_srcA = '0, IN_srcB = '0;
  logic [6:0] IN_tagDst = '0, IN_sqN = '0, IN_branchSqN = '0;
  logic OUT_busy, OUT_valid;
  logic [31:0] OUT_result;
  logic [6:0] OUT_tagDst, OUT_sqN;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  int_div_unit dut (
    .clk(clk), .rst(rst), .IN_valid(IN_valid), .IN_opcode(IN_opcode),
    .IN_srcA(IN_srcA), .IN_srcB(IN_srcB), .IN_tagDst(IN_tagDst), .IN_sqN(IN_sqN),
    .IN_branchTaken(IN_branchTaken), .IN_branchSqN(IN_branchSqN),
    .OUT_busy(OUT_busy), .OUT_valid(OUT_valid), .OUT_result(OUT_result),
    .OUT_tagDst(OUT_tagDst), .OUT_sqN(OUT_sqN)
  );
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFFFFFF;
    if (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return op[1] ? 32'h0 : 32'h80000000;
    case (op)
      2'd0: return sa / sb;
      2'd1: return a / b;
      2'd2: return sa % sb;
      default: return a % b;
    endcase
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [6:0] tag, input logic [6:0] sqn);
    IN_valid = 1'b1;
    IN_opcode = op;
    IN_srcA = a;
    IN_srcB = b;
    IN_tagDst = tag;
    IN_sqN = sqn;
    @(negedge clk);
    IN_valid = 1'b0;
  endtask
  task automatic wait_done(input int start, output int lat, output int busy);
    lat = start;
    busy = 0;
    while (!OUT_valid && lat < 100) begin
      if (OUT_busy) busy++;
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic quiet(input int n);
    int seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (OUT_valid) seen++;
    end
    check("no_valid", 32'(seen), 32'd0);
  endtask
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [6:0] tag, input logic [6:0] sqn);
    int lat, bc;
    issue(op, a, b, tag, sqn);
    wait_done(1, lat, bc);
    check("latency", 32'(lat), 32'd33);
    check("busy_cycles", 32'(bc), 32'd32);
    check("busy_at_valid", {31'd0, OUT_busy}, 32'd0);
    check("result", OUT_result, model(op, a, b));
    check("tag", {25'd0, OUT_tagDst}, {25'd0, tag});
    check("sqn", {25'd0, OUT_sqN}, {25'd0, sqn});
  endtask
  task automatic flush_test(input logic [6:0] sqn, input logic [6:0] bsqn, input logic kill);
    int lat, bc;
    issue(2'd1, 32'd100, 32'd7, 7'd9, sqn);
    repeat (11) @(negedge clk);
    IN_branchTaken = 1'b1;
    IN_branchSqN = bsqn;
    @(negedge clk);
    IN_branchTaken = 1'b0;
    if (kill) begin
      check("flush_busy", {31'd0, OUT_busy}, 32'd0);
      quiet(40);
    end else begin
      wait_done(13, lat, bc);
      check("flush_keep_lat", 32'(lat), 32'd33);
      check("flush_keep_result", OUT_result, 32'd14);
    end
  endtask
  initial begin
    int lat, bc;
    logic [1:0] op;
    logic [31:0] a, b;
    repeat (2) @(negedge clk);
    check("reset_busy", {31'd0, OUT_busy}, 32'd0);
    check("reset_valid", {31'd0, OUT_valid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run_op(2'd1, 32'd100, 32'd7, 7'd5, 7'd3);
    run_op(2'd2, 32'hFFFFFFF9, 32'd2, 7'd6, 7'd4);
    run_op(2'd0, 32'hFFFFFFF9, 32'd2, 7'h45, 7'd5);
    run_op(2'd3, 32'd7, 32'd0, 7'd7, 7'd6);
    run_op(2'd0, 32'd5, 32'd0, 7'd8, 7'd7);
    run_op(2'd0, 32'hFFFFFFFB, 32'd0, 7'd9, 7'd8);
    run_op(2'd2, 32'hFFFFFFFB, 32'd0, 7'd10, 7'd9);
    run_op(2'd0, 32'h80000000, 32'hFFFFFFFF, 7'd11, 7'd10);
    run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 7'd12, 7'd11);
    run_op(2'd1, 32'hFFFFFFFF, 32'd1, 7'd13, 7'd127);
    flush_test(7'd10, 7'd8, 1'b1);
    flush_test(7'd10, 7'd12, 1'b0);
    flush_test(7'd1, 7'd126, 1'b1);
    issue(2'd1, 32'd1000, 32'd10, 7'd20, 7'd20);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_busy", {31'd0, OUT_busy}, 32'd0);
    check("rst_mid_valid", {31'd0, OUT_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(2'd1, 32'd1000, 32'd10, 7'd21, 7'd21);
    issue(2'd3, 32'd12345, 32'd100, 7'd30, 7'd30);
    wait_done(1, lat, bc);
    check("b2b_first_lat", 32'(lat), 32'd33);
    check("b2b_first_result", OUT_result, 32'd45);
    issue(2'd0, 32'hFFFFFC18, 32'd7, 7'd31, 7'd31);
    repeat (4) @(negedge clk);
    IN_valid = 1'b1;
    IN_opcode = 2'd1;
    IN_srcA = 32'd9;
    IN_srcB = 32'd3;
    IN_sqN = 7'd40;
    @(negedge clk);
    IN_valid = 1'b0;
    wait_done(6, lat, bc);
    check("b2b_second_lat", 32'(lat), 32'd33);
    check("b2b_second_result", OUT_result, 32'hFFFFFF72);
    check("b2b_second_sqn", {25'd0, OUT_sqN}, 32'd31);
    quiet(40);
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($signed($urandom_range(0, 6)) - 3) : $urandom >> $urandom_range(0, 31);
      run_op(op, a, b, 7'($urandom), 7'($urandom));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/int_div_unit.md
Name: int_div_unit

Overview:
- Iterative radix-2 integer divider for the DIV execution port.
- Accepts one issued divide uop with operands already read, and runs a fixed number of iterations.
- Broadcasts the result, destination tag and sqN as a single-cycle writeback on the result bus.
- Drives the busy signal that the issue side uses as its "do not issue div" input, and squashes in-flight work on mispredict.

Parameters:
- XLEN, 32, operand/result width.
- TAG_W, 7, destination tag width; MSB set = no register writeback.
- SQN_W, 7, sequence number width; compared modulo 2^SQN_W.
- ITERS, 32, quotient bits per op (= XLEN); fixed latency = ITERS+1 = 33 cycles.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- IN_valid  in  1  issued divide uop present this cycle
- IN_opcode  in  2  0=DIV, 1=DIVU, 2=REM, 3=REMU
- IN_srcA  in  XLEN  dividend
- IN_srcB  in  XLEN  divisor
- IN_tagDst  in  TAG_W  destination tag
- IN_sqN  in  SQN_W  uop sequence number
- IN_branchTaken  in  1  mispredict flush this cycle
- IN_branchSqN  in  SQN_W  sqN of mispredicting op; strictly younger ops are killed
- OUT_busy  out  1  unit occupied; issue must not send another divide
- OUT_valid  out  1  result valid (exactly one cycle)
- OUT_result  out  XLEN  quotient or remainder
- OUT_tagDst  out  TAG_W  tag of completed op
- OUT_sqN  out  SQN_W  sqN of completed op

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, OUT_busy=0, OUT_valid=0.
  - OUT_result, OUT_tagDst and OUT_sqN are don't-care.
  - Reset mid-operation discards the op silently.
- States: IDLE -> RUN -> DONE -> IDLE.
- Kill test: "younger" means $signed(sqN - IN_branchSqN) > 0, computed at SQN_W width so wrap-around is handled.
- IDLE:
  - On IN_valid, and not (IN_branchTaken with IN_sqN younger), latch the operands, opcode, tag and sqN.
  - Signed ops: record the sign of the dividend and the sign of the divisor, then store their magnitudes.
  - Set counter=ITERS-1, go to RUN, OUT_busy=1 from the next cycle.
- RUN, one iteration per cycle:
  - rem = {rem, quo[MSB]} − divisor if non-negative, else restore.
  - Shift the resulting quotient bit in.
  - Counter decrements; on counter=0 go to DONE.
- DONE:
  - Apply sign fixup: quotient negated if the recorded signs differ (DIV); remainder takes the dividend's sign (REM).
  - Register outputs: OUT_valid=1 for exactly one cycle.
  - The cycle OUT_valid is high is the 33rd after the accepting edge. This is fixed regardless of operands, so issue-side writeback reservation is exact.
  - Return to IDLE; OUT_busy falls in the same cycle OUT_valid rises.
- Special cases (still full latency):
  - Divide by zero: quotient = all ones, remainder = dividend.
  - DIV/REM with INT_MIN / −1: quotient = INT_MIN, remainder = 0.
- Flush:
  - In RUN or DONE, if IN_branchTaken and the held sqN is younger, go to IDLE next edge; no OUT_valid, OUT_busy=0 next cycle.
  - An older or equal sqN continues unaffected.
  - A flush in the cycle OUT_valid is already high does not retract it.
- No backpressure: the writeback slot is pre-reserved, so there is no stall input.
- IN_valid while OUT_busy=1 is a protocol violation:
  - The input is ignored and the in-flight op is unaffected.
  - A debug assertion fires.
- Back-to-back: a new IN_valid is accepted in the same cycle OUT_valid is high. Its result appears 33 cycles later.
- OUT_tagDst with MSB set is still reported; consumers gate register writes.

Test Plan:
- DIVU 100/7, tag=5, sqN=3 -> OUT_valid exactly 33 cycles later, result=14, tag=5, sqN=3; OUT_busy high cycles 1–32.
- REM −7/2 -> result 0xFFFFFFFF (−1); DIV −7/2 -> 0xFFFFFFFD (−3); REMU 7/0 -> 7; DIV 5/0 -> 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same -> 0; latency still 33.
- Op sqN=10 in RUN, branch sqN=8 at cycle 12 -> no OUT_valid, OUT_busy=0 at cycle 13. Repeat with branch sqN=12 -> completes normally. Repeat with op sqN=1, branch sqN=126 (wrap) -> killed.
- Assert rst at cycle 20 of an op -> outputs idle immediately; next op after reset completes with correct result.
- Issue a new op in the OUT_valid cycle -> both results correct, 33 cycles apart; IN_valid while busy -> ignored, first result intact.
